not16_skid_in: RTL and testbench



---
 rtl/not16_skid_in.sv | 98 +++++++++
 tb/tb_not16_skid_in.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/not16_skid_in.sv
`default_nettype none
// ============================================================================
// Module   : not16_skid_in
// Purpose  : Two-entry valid/ready skid buffer feeding the 16-bit inverter.
//            Optional accepted-word counter: define NOT16_SKID_COUNT_EN.
// Revision : 1.0
// ============================================================================
module not16_skid_in #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    input  logic             out_ready
`ifdef NOT16_SKID_COUNT_EN
    ,
    output logic [15:0]      count
`endif
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             w_acc;
    logic             w_pop;

    // in_ready comes straight from the skid flop, so out_ready never reaches it.
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out       = main_data_q;

    assign w_acc = in_valid & ~skid_valid_q;
    assign w_pop = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q) begin
            if (w_acc) begin
                main_data_d  = in;
                main_valid_d = 1'b1;
            end
        end else if (w_pop) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (w_acc) begin
                main_data_d  = in;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!skid_valid_q && w_acc) begin
            skid_data_d  = in;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef NOT16_SKID_COUNT_EN
    localparam int c_CNT_W = 16;

    logic [c_CNT_W-1:0] count_q, count_d;

    // Natural modulo-2^16 wrap.
    assign count_d = w_acc ? count_q + 1'b1 : count_q;
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_not16_skid_in.sv
`default_nettype none
// Bench for not16_skid_in: queue-based reference model, per-cycle compare,
// directed literal checks and randomized traffic.
module tb_not16_skid_in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
`ifdef NOT16_SKID_COUNT_EN
    logic [15:0] count;
`endif

    int checks = 0;
    int failures = 0;

    not16_skid_in #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out_data),
        .out_ready (out_ready)
`ifdef NOT16_SKID_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of capacity two plus the last word shown on out.
    logic [15:0] mq[$];
    logic [15:0] m_last = 16'h0;
    logic [15:0] m_cnt = 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 16'h0;
            m_cnt  = 16'h0;
        end else begin
            automatic bit acc = in_valid && (mq.size() < 2);
            automatic bit pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(in_data);
                m_cnt = m_cnt + 16'h1;
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        check("model_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
        check("model_out",       {16'b0, out_data},  {16'b0, m_last});
`ifdef NOT16_SKID_COUNT_EN
        check("model_count",     {16'b0, count},     {16'b0, m_cnt});
`endif
    end

    // Apply one cycle of inputs; return just after the following falling edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic ov, input logic ir, input logic [15:0] o);
        check({name, "_out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        check({name, "_in_ready"},  {31'b0, in_ready},  {31'b0, ir});
        check({name, "_out"},       {16'b0, out_data},  {16'b0, o});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        drive(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 1'b0);
            chk_state("idle", 1'b0, 1'b1, 16'h0000);
        end

        // Streaming with zero bubbles.
        drive(1'b1, 16'h00FF, 1'b1);
        chk_state("stream0", 1'b1, 1'b1, 16'h00FF);
        check("inv0", {16'b0, ~out_data}, 32'hFF00);
        drive(1'b1, 16'hFF00, 1'b1);
        chk_state("stream1", 1'b1, 1'b1, 16'hFF00);
        check("inv1", {16'b0, ~out_data}, 32'h00FF);
        drive(1'b1, 16'hAAAA, 1'b1);
        chk_state("stream2", 1'b1, 1'b1, 16'hAAAA);
        check("inv2", {16'b0, ~out_data}, 32'h5555);
        drive(1'b0, 16'h0, 1'b1);
        chk_state("stream_empty", 1'b0, 1'b1, 16'hAAAA);

        // Backpressure fill.
        drive(1'b1, 16'h1234, 1'b0);
        chk_state("fill1", 1'b1, 1'b1, 16'h1234);
        drive(1'b1, 16'h5678, 1'b0);
        chk_state("fill2", 1'b1, 1'b0, 16'h1234);
        drive(1'b1, 16'h9ABC, 1'b0);
        chk_state("full_hold", 1'b1, 1'b0, 16'h1234);

        // Drain in order; 9ABC enters once in_ready returns.
        drive(1'b1, 16'h9ABC, 1'b1);
        chk_state("drain1", 1'b1, 1'b1, 16'h5678);
        drive(1'b1, 16'h9ABC, 1'b1);
        chk_state("drain2", 1'b1, 1'b1, 16'h9ABC);
        drive(1'b0, 16'h0, 1'b1);
        chk_state("drain_empty", 1'b0, 1'b1, 16'h9ABC);

        // Asynchronous reset while full.
        drive(1'b1, 16'h1111, 1'b0);
        drive(1'b1, 16'h2222, 1'b0);
        chk_state("prefull", 1'b1, 1'b0, 16'h1111);
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 1'b1, 16'h0000);
        #1 rst_n = 1'b1;
        drive(1'b0, 16'h0, 1'b1);
        chk_state("post_rst", 1'b0, 1'b1, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom()), ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 8), 16'($urandom()), ($urandom_range(0, 9) < 3));
        end

`ifdef NOT16_SKID_COUNT_EN
        rst_n = 1'b0;
        #1;
        check("count_rst", {16'b0, count}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 65534; i++) drive(1'b1, 16'(i), 1'b1);
        check("count_fffe", {16'b0, count}, 32'hFFFE);
        drive(1'b1, 16'h0, 1'b1);
        check("count_ffff", {16'b0, count}, 32'hFFFF);
        drive(1'b1, 16'h0, 1'b1);
        check("count_wrap", {16'b0, count}, 32'h0000);
`endif

        drive(1'b0, 16'h0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
